// File: rtl/hack_decoder_if.sv
// hack_decoder_if: instruction-in / control-out bundle for the Hack decoder.
// The master side is the surrounding CPU (fetch stage, ALU/datapath);
// the slave side is the decoder itself.
interface hack_decoder_if;

  // Upstream instruction handshake
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;

  // Downstream control handshake
  logic        ctl_valid;
  logic        ctl_ready;

  // Decoded A-instruction fields
  logic        is_a;
  logic [14:0] a_value;

  // Decoded C-instruction fields
  logic        a_sel;
  logic        zx;
  logic        nx;
  logic        zy;
  logic        ny;
  logic        f;
  logic        no;
  logic        dest_a;
  logic        dest_d;
  logic        dest_m;

  // ALU flags returned by the datapath, and the jump decision
  logic        zr;
  logic        ng;
  logic        pc_load;

  // Sticky illegal-instruction indicator
  logic        illegal;

  modport master (
    output instr_valid, instr, ctl_ready, zr, ng,
    input  instr_ready, ctl_valid, is_a, a_value, a_sel,
           zx, nx, zy, ny, f, no, dest_a, dest_d, dest_m,
           pc_load, illegal
  );

  modport slave (
    input  instr_valid, instr, ctl_ready, zr, ng,
    output instr_ready, ctl_valid, is_a, a_value, a_sel,
           zx, nx, zy, ny, f, no, dest_a, dest_d, dest_m,
           pc_load, illegal
  );

endinterface

// File: rtl/hack_decoder.sv
// hack_decoder: Hack CPU instruction decoder with valid/ready handshakes.
// An accepted instruction is decoded into held control fields, presented to
// the datapath until accepted, and C-instructions then spend one RESOLVE
// cycle evaluating the jump condition against the live ALU flags.
// Optional feature: define HACK_DECODER_ILLEGAL_EN to flag C-instructions
// whose two reserved top bits are not 2'b11; such words are issued as NOPs
// and set the sticky illegal output. Without it, illegal is tied low.
module hack_decoder (
  input logic           clk,
  input logic           resetn,
  hack_decoder_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;

  logic        accept;
  logic        issue_done;
  logic        legal;
  logic        take;

  // Combinational decode of the incoming word
  logic        dec_is_a;
  logic [14:0] dec_a_value;
  logic        dec_a_sel;
  logic [5:0]  dec_alu;
  logic [2:0]  dec_dest;
  logic [2:0]  dec_jump;

  // Held copies presented while the instruction is in flight
  logic        is_a_q;
  logic [14:0] a_value_q;
  logic        a_sel_q;
  logic [5:0]  alu_q;
  logic [2:0]  dest_q;
  logic [2:0]  jump_q;

  assign accept     = (state == IDLE) && bus.instr_valid;
  assign issue_done = (state == ISSUE) && bus.ctl_ready;

`ifdef HACK_DECODER_ILLEGAL_EN
  assign legal = (bus.instr[14:13] == 2'b11);
`else
  assign legal = 1'b1;
`endif

  // Split the incoming word into A-literal or C-instruction control fields
  always_comb begin
    dec_is_a    = ~bus.instr[15];
    dec_a_value = 15'd0;
    dec_a_sel   = 1'b0;
    dec_alu     = 6'd0;
    dec_dest    = 3'd0;
    dec_jump    = 3'd0;
    if (!bus.instr[15]) begin
      dec_a_value = bus.instr[14:0];
    end else if (legal) begin
      dec_a_sel = bus.instr[12];
      dec_alu   = bus.instr[11:6];
      dec_dest  = bus.instr[5:3];
      dec_jump  = bus.instr[2:0];
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> (RESOLVE) -> IDLE sequence
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.instr_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.ctl_ready) begin
          state_next = is_a_q ? IDLE : RESOLVE;
        end
      end
      RESOLVE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture decoded fields only when a new instruction is accepted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_a_q    <= 1'b0;
      a_value_q <= 15'd0;
      a_sel_q   <= 1'b0;
      alu_q     <= 6'd0;
      dest_q    <= 3'd0;
      jump_q    <= 3'd0;
    end else if (accept) begin
      is_a_q    <= dec_is_a;
      a_value_q <= dec_a_value;
      a_sel_q   <= dec_a_sel;
      alu_q     <= dec_alu;
      dest_q    <= dec_dest;
      jump_q    <= dec_jump;
    end
  end

`ifdef HACK_DECODER_ILLEGAL_EN
  logic illegal_q;

  // Latch any accepted C-instruction with bad reserved bits until reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      illegal_q <= 1'b0;
    end else if (accept && bus.instr[15] && !legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  // Flags only matter here because pc_load is gated by the RESOLVE state
  assign take = (jump_q[2] & bus.ng)
              | (jump_q[1] & bus.zr)
              | (jump_q[0] & ~bus.ng & ~bus.zr);

  assign bus.pc_load     = (state == RESOLVE) && take;
  assign bus.instr_ready = (state == IDLE);
  assign bus.ctl_valid   = (state == ISSUE);

  assign bus.is_a    = is_a_q;
  assign bus.a_value = a_value_q;
  assign bus.a_sel   = a_sel_q;
  assign bus.zx      = alu_q[5];
  assign bus.nx      = alu_q[4];
  assign bus.zy      = alu_q[3];
  assign bus.ny      = alu_q[2];
  assign bus.f       = alu_q[1];
  assign bus.no      = alu_q[0];
  assign bus.dest_a  = dest_q[2];
  assign bus.dest_d  = dest_q[1];
  assign bus.dest_m  = dest_q[0];

  // The issue handshake has no further use beyond documenting intent
  logic unused_ok;
  assign unused_ok = issue_done;

endmodule

// File: tb/tb_hack_decoder.sv
// tb_hack_decoder: directed self-checking bench for hack_decoder.
// Expected values are hand-decoded from the Hack instruction encoding.
module tb_hack_decoder;

  logic clk;
  logic resetn;
  int   tests_run;
  int   tests_failed;

  hack_decoder_if bus ();

  hack_decoder dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // {is_a, a_value, a_sel, zx, nx, zy, ny, f, no, dest_a, dest_d, dest_m}
  localparam logic [25:0] CW_ZERO = 26'd0;
  localparam logic [25:0] CW_A5   = {1'b1, 15'd5, 10'd0};
  localparam logic [25:0] CW_A3   = {1'b1, 15'd3, 10'd0};
  localparam logic [25:0] CW_A4   = {1'b1, 15'd4, 10'd0};
  localparam logic [25:0] CW_EC10 = {1'b0, 15'd0, 1'b0, 6'b110000, 3'b010};

`ifdef HACK_DECODER_ILLEGAL_EN
  localparam logic EXP_ILLEGAL = 1'b1;
  localparam logic EXP_ILL_JMP = 1'b0;
`else
  localparam logic EXP_ILLEGAL = 1'b0;
  localparam logic EXP_ILL_JMP = 1'b1;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [25:0] ctl_word();
    return {bus.is_a, bus.a_value, bus.a_sel, bus.zx, bus.nx, bus.zy,
            bus.ny, bus.f, bus.no, bus.dest_a, bus.dest_d, bus.dest_m};
  endfunction

  // Present one word for a single accepting edge; returns just after that edge
  task automatic drive_instr(input logic [15:0] w);
    @(negedge clk);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn          = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.ctl_ready   = 1'b1;
    bus.zr          = 1'b0;
    bus.ng          = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.instr_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_instr_ready: got %b expected 1", bus.instr_ready);
    end
    tests_run++;
    if ({bus.ctl_valid, bus.pc_load, bus.illegal} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {bus.ctl_valid, bus.pc_load, bus.illegal});
    end
    tests_run++;
    if (ctl_word() !== CW_ZERO) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctl: got %h expected %h", ctl_word(), CW_ZERO);
    end
    resetn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.instr_ready !== 1'b1 || bus.ctl_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_idle: got rdy=%b vld=%b expected rdy=1 vld=0", bus.instr_ready, bus.ctl_valid);
    end
  endtask

  task automatic test_a_instr();
    bus.ctl_ready = 1'b1;
    drive_instr(16'h0005);
    @(negedge clk);
    tests_run++;
    if (bus.ctl_valid !== 1'b1 || bus.instr_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL a_issue_hs: got vld=%b rdy=%b expected vld=1 rdy=0", bus.ctl_valid, bus.instr_ready);
    end
    tests_run++;
    if (ctl_word() !== CW_A5) begin
      tests_failed++;
      $display("[TB] FAIL a_issue_ctl: got %h expected %h", ctl_word(), CW_A5);
    end
    tests_run++;
    if (bus.pc_load !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL a_issue_pc_load: got %b expected 0", bus.pc_load);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.instr_ready, bus.ctl_valid, bus.pc_load} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL a_back_idle: got rdy,vld,pc=%b expected 100", {bus.instr_ready, bus.ctl_valid, bus.pc_load});
    end
  endtask

  task automatic test_decode_c();
    bus.ctl_ready = 1'b1;
    drive_instr(16'hEC10);
    @(negedge clk);
    tests_run++;
    if (bus.ctl_valid !== 1'b1 || ctl_word() !== CW_EC10) begin
      tests_failed++;
      $display("[TB] FAIL c_decode: got vld=%b ctl=%h expected vld=1 ctl=%h", bus.ctl_valid, ctl_word(), CW_EC10);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.ctl_valid, bus.instr_ready, bus.pc_load} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL c_resolve: got vld,rdy,pc=%b expected 000", {bus.ctl_valid, bus.instr_ready, bus.pc_load});
    end
    @(negedge clk);
    tests_run++;
    if (bus.instr_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL c_back_idle: got rdy=%b expected 1", bus.instr_ready);
    end
  endtask

  task automatic test_jump();
    // {word, zr, ng, expected pc_load}
    logic [18:0] vec [9];
    vec[0] = {16'hE302, 1'b1, 1'b0, 1'b1};
    vec[1] = {16'hE302, 1'b0, 1'b0, 1'b0};
    vec[2] = {16'hE307, 1'b0, 1'b0, 1'b1};
    vec[3] = {16'hE307, 1'b1, 1'b1, 1'b1};
    vec[4] = {16'hE304, 1'b0, 1'b1, 1'b1};
    vec[5] = {16'hE304, 1'b0, 1'b0, 1'b0};
    vec[6] = {16'hE301, 1'b0, 1'b0, 1'b1};
    vec[7] = {16'hE301, 1'b1, 1'b0, 1'b0};
    vec[8] = {16'hEC10, 1'b1, 1'b1, 1'b0};
    bus.ctl_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_instr(vec[i][18:3]);
      bus.zr = ~vec[i][2];
      bus.ng = ~vec[i][1];
      @(negedge clk);
      tests_run++;
      if (bus.pc_load !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL jump_issue_%0d: got pc_load=%b expected 0", i, bus.pc_load);
      end
      @(posedge clk);
      #1;
      bus.zr = vec[i][2];
      bus.ng = vec[i][1];
      @(negedge clk);
      tests_run++;
      if (bus.pc_load !== vec[i][0]) begin
        tests_failed++;
        $display("[TB] FAIL jump_resolve_%0d: got pc_load=%b expected %b", i, bus.pc_load, vec[i][0]);
      end
      @(negedge clk);
      tests_run++;
      if (bus.pc_load !== 1'b0 || bus.instr_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL jump_after_%0d: got pc=%b rdy=%b expected pc=0 rdy=1", i, bus.pc_load, bus.instr_ready);
      end
    end
    bus.zr = 1'b0;
    bus.ng = 1'b0;
  endtask

  task automatic test_stall();
    bus.ctl_ready = 1'b0;
    drive_instr(16'hEC10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.ctl_valid, bus.instr_ready, bus.pc_load} !== 3'b100 || ctl_word() !== CW_EC10) begin
        tests_failed++;
        $display("[TB] FAIL stall_%0d: got vld,rdy,pc=%b ctl=%h expected 100 ctl=%h", i, {bus.ctl_valid, bus.instr_ready, bus.pc_load}, ctl_word(), CW_EC10);
      end
      bus.instr       = 16'h0005;
      bus.instr_valid = (i % 2 == 0);
    end
    bus.instr_valid = 1'b0;
    bus.ctl_ready   = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.ctl_valid, bus.instr_ready, bus.pc_load} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got vld,rdy,pc=%b expected 000", {bus.ctl_valid, bus.instr_ready, bus.pc_load});
    end
    @(negedge clk);
    tests_run++;
    if (bus.instr_ready !== 1'b1 || ctl_word() !== CW_EC10) begin
      tests_failed++;
      $display("[TB] FAIL stall_no_capture: got rdy=%b ctl=%h expected rdy=1 ctl=%h", bus.instr_ready, ctl_word(), CW_EC10);
    end
  endtask

  task automatic test_reset_mid();
    bus.ctl_ready = 1'b1;
    bus.zr        = 1'b0;
    bus.ng        = 1'b0;
    drive_instr(16'hE307);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.pc_load !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_pre: got pc_load=%b expected 1", bus.pc_load);
    end
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({bus.pc_load, bus.ctl_valid, bus.instr_ready, bus.illegal} !== 4'b0010 || ctl_word() !== CW_ZERO) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_async: got pc,vld,rdy,ill=%b ctl=%h expected 0010 ctl=0", {bus.pc_load, bus.ctl_valid, bus.instr_ready, bus.illegal}, ctl_word());
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.pc_load, bus.ctl_valid, bus.instr_ready} !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_release: got pc,vld,rdy=%b expected 001", {bus.pc_load, bus.ctl_valid, bus.instr_ready});
    end
  endtask

  task automatic test_illegal();
    bus.ctl_ready = 1'b1;
    bus.zr        = 1'b0;
    bus.ng        = 1'b0;
    drive_instr(16'h8007);
    @(negedge clk);
    tests_run++;
    if (bus.illegal !== EXP_ILLEGAL || bus.ctl_valid !== 1'b1 || ctl_word() !== CW_ZERO) begin
      tests_failed++;
      $display("[TB] FAIL illegal_issue: got ill=%b vld=%b ctl=%h expected ill=%b vld=1 ctl=0", bus.illegal, bus.ctl_valid, ctl_word(), EXP_ILLEGAL);
    end
    @(negedge clk);
    tests_run++;
    if (bus.pc_load !== EXP_ILL_JMP) begin
      tests_failed++;
      $display("[TB] FAIL illegal_pc_load: got %b expected %b", bus.pc_load, EXP_ILL_JMP);
    end
    drive_instr(16'hEC10);
    @(negedge clk);
    tests_run++;
    if (bus.illegal !== EXP_ILLEGAL || ctl_word() !== CW_EC10) begin
      tests_failed++;
      $display("[TB] FAIL illegal_sticky: got ill=%b ctl=%h expected ill=%b ctl=%h", bus.illegal, ctl_word(), EXP_ILLEGAL, CW_EC10);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.ctl_ready = 1'b1;
    @(negedge clk);
    bus.instr       = 16'h0003;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.ctl_valid !== 1'b1 || ctl_word() !== CW_A3) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got vld=%b ctl=%h expected vld=1 ctl=%h", bus.ctl_valid, ctl_word(), CW_A3);
    end
    bus.instr = 16'h0004;
    @(negedge clk);
    tests_run++;
    if (bus.instr_ready !== 1'b1 || bus.ctl_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_gap: got rdy=%b vld=%b expected rdy=1 vld=0", bus.instr_ready, bus.ctl_valid);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    tests_run++;
    if (bus.ctl_valid !== 1'b1 || ctl_word() !== CW_A4) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got vld=%b ctl=%h expected vld=1 ctl=%h", bus.ctl_valid, ctl_word(), CW_A4);
    end
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_a_instr();
    test_decode_c();
    test_jump();
    test_stall();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hack_decoder.md
HACK_DECODER -- requirements
Module: hack_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have ports: resetn  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: instr_valid  in  1  upstream instruction valid.
REQ-004 SHALL have ports: instr_ready  out  1  decoder can accept an instruction.
REQ-005 SHALL have ports: instr  in  16  Hack instruction word.
REQ-006 SHALL have ports: ctl_valid  out  1  decoded controls valid to the ALU/datapath.
REQ-007 SHALL have ports: ctl_ready  in  1  datapath accepts controls.
REQ-008 SHALL have ports: is_a  out  1  held word is an A-instruction.
REQ-009 SHALL have ports: a_value  out  15  A-instruction literal, instr[14:0].
REQ-010 SHALL have ports: a_sel  out  1  ALU y operand from M (1) or A (0), instr[12].
REQ-011 SHALL have ports: zx, nx, zy, ny, f, no  out  1 each  ALU controls, instr[11:6] in that order.
REQ-012 SHALL have ports: dest_a, dest_d, dest_m  out  1 each  destination writes, instr[5:3].
REQ-013 SHALL have ports: zr, ng  in  1 each  ALU result flags.
REQ-014 SHALL have ports: pc_load  out  1  one-cycle pulse, jump taken.
REQ-015 SHALL have ports: illegal  out  1  sticky illegal-instruction flag (macro only, REQ-032).

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, RESOLVE.
REQ-017 IDLE: instr_ready=1, ctl_valid=0; on instr_valid=1 SHALL register the decoded fields and go to ISSUE.
REQ-018 Decode: instr[15]=0 -> is_a=1, a_value=instr[14:0], all ALU/dest/jump fields 0; instr[15]=1 -> is_a=0, fields per REQ-010..012, jump bits j1..j3=instr[2:0] held internally.
REQ-019 ISSUE: ctl_valid=1, instr_ready=0, all control outputs stable until ctl_valid&&ctl_ready.
REQ-020 On ISSUE handshake: A-instruction -> IDLE; C-instruction -> RESOLVE.
REQ-021 RESOLVE, one cycle: take = (j1&ng)|(j2&zr)|(j3&~ng&~zr); pc_load=take for exactly this cycle; then IDLE.
REQ-022 pc_load SHALL be 0 in all other states and for A-instructions.
REQ-023 Latency: instruction accepted at edge N -> ctl_valid high from N+1; with ctl_ready=1 at N+1, pc_load valid during cycle N+2; next instruction accepted no earlier than N+3 (C) or N+2 (A).
REQ-024 ctl_ready held low SHALL stall indefinitely in ISSUE with outputs unchanged; instr_valid ignored outside IDLE.
REQ-025 jump=111 SHALL give take=1 irrespective of flags; jump=000 SHALL give take=0.
REQ-026 zr and ng SHALL only be sampled in RESOLVE.

Reset
REQ-027 resetn=0 SHALL asynchronously force state IDLE and all registered outputs 0 (ctl_valid, pc_load, is_a, a_value, a_sel, zx..no, dest_*, illegal).
REQ-028 Reset mid-operation (ISSUE or RESOLVE) SHALL abort the instruction; no pc_load pulse follows.
REQ-029 instr_ready SHALL be 1 while resetn=0 is released into IDLE.

Configuration
REQ-030 Macro HACK_DECODER_ILLEGAL_EN SHALL gate illegal-instruction checking.
REQ-031 With macro: a C-instruction with instr[14:13]!=2'b11 SHALL set illegal (sticky until reset) and be issued as a NOP (all ALU/dest/jump fields 0); handshake unchanged.
REQ-032 Without macro: illegal port tied 0; instr[14:13] ignored.

Verification
REQ-033 Reset, then instr=16'h0005, valid 1 cycle, ctl_ready=1 -> ctl_valid next cycle, is_a=1, a_value=5, pc_load never pulses, back in IDLE 2 cycles later.
REQ-034 instr=16'hEC10 (D=A) -> a_sel=0, zx..no=110000, dest_d=1, dest_a=dest_m=0, pc_load=0.
REQ-035 instr=16'hE302 (D;JEQ) with zr=1, ng=0 in RESOLVE -> pc_load=1 one cycle; repeat with zr=0 -> pc_load=0.
REQ-036 ctl_ready low for 10 cycles in ISSUE -> controls stable, instr_ready=0, instr_valid pulses ignored; ctl_ready high -> proceeds normally.
REQ-037 Assert resetn=0 during RESOLVE of 16'hE307 -> pc_load=0, all outputs 0, instr_ready=1 after release.
REQ-038 Macro defined, instr=16'h8007 -> illegal=1 and stays 1, controls all 0, pc_load=0; macro undefined -> illegal=0, pc_load=1.
